// File: rtl/freq_count.sv
// Symbol-frequency counter feeding the sorter: tallies NSYM symbol codes per run
// and pulses count_over once the packed count vector is final.
module freq_count #(
  parameter int NSYM = 10,
  parameter int CW   = 13,
  parameter int SW   = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 count_begin,
  input  logic                 data_valid,
  input  logic [SW-1:0]        DATA_IN,
  input  logic                 data_last,
  output logic                 busy,
  output logic                 count_over,
  output logic                 bad_sym,
  output logic [NSYM*CW-1:0]   FREQUENT_OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [31:0]   NSYM_U   = NSYM;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q [NSYM];
  logic [CW-1:0] cnt_d [NSYM];
  logic          bad_q, bad_d;
  logic          busy_q, busy_d;
  logic          over_q, over_d;
  logic [31:0]   sym_ext_s;
  logic          sym_ok_s;

  assign sym_ext_s = 32'(DATA_IN);
  assign sym_ok_s  = (sym_ext_s < NSYM_U);

  // Next-state, count update and registered-output decode.
  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    for (int i = 0; i < NSYM; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    case (state_q)
      IDLE: begin
        if (count_begin) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        for (int i = 0; i < NSYM; i++) begin
          cnt_d[i] = CNT_ZERO;
        end
        bad_d   = 1'b0;
        state_d = COUNT;
      end
      COUNT: begin
        if (data_valid) begin
          if (sym_ok_s) begin
            for (int i = 0; i < NSYM; i++) begin
              // Saturate: a full counter simply keeps its value.
              if ((sym_ext_s == 32'(i)) && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
              end else begin
                cnt_d[i] = cnt_q[i];
              end
            end
          end else begin
            bad_d = 1'b1;
          end
          if (data_last) begin
            state_d = DONE;
          end else begin
            state_d = COUNT;
          end
        end else begin
          state_d = COUNT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CLEAR) || (state_d == COUNT);
    // count_over is registered off DONE, so it lands one cycle after DONE.
    over_d = (state_q == DONE);
  end

  // State, count and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
      for (int i = 0; i < NSYM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NSYM; g++) begin : g_pack
    assign FREQUENT_OUT[CW*g +: CW] = cnt_q[g];
  end

  assign busy       = busy_q;
  assign count_over = over_q;
  assign bad_sym    = bad_q;

endmodule

// File: tb/tb_freq_count.sv
// Randomised bench for freq_count against a plain-arithmetic histogram model.
module tb_freq_count;
  localparam int NSYM = 10;
  localparam int CW   = 13;
  localparam int SW   = 4;
  localparam int MAXC = 8191;

  logic                CLK = 1'b0;
  logic                nRST;
  logic                count_begin;
  logic                data_valid;
  logic [SW-1:0]       DATA_IN;
  logic                data_last;
  logic                busy;
  logic                count_over;
  logic                bad_sym;
  logic [NSYM*CW-1:0]  FREQUENT_OUT;

  freq_count #(.NSYM(NSYM), .CW(CW), .SW(SW)) dut (
    .CLK(CLK), .nRST(nRST), .count_begin(count_begin), .data_valid(data_valid),
    .DATA_IN(DATA_IN), .data_last(data_last), .busy(busy), .count_over(count_over),
    .bad_sym(bad_sym), .FREQUENT_OUT(FREQUENT_OUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int exp_cnt [NSYM];
  bit exp_bad;
  int sym_q [$];
  bit vld_q [$];
  bit lst_q [$];

  always @(negedge CLK) begin
    if (count_over === 1'b1) pulses++;
  end

  function automatic logic [NSYM*CW-1:0] pack_exp();
    logic [NSYM*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NSYM; i++) r[i*CW +: CW] = CW'(exp_cnt[i]);
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [NSYM*CW-1:0] got,
                           input logic [NSYM*CW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input int s, input bit v, input bit l);
    sym_q.push_back(s);
    vld_q.push_back(v);
    lst_q.push_back(l);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NSYM; i++) exp_cnt[i] = 0;
    exp_bad = 1'b0;
  endtask

  task automatic model_symbol(input int s);
    if (s < NSYM) begin
      if (exp_cnt[s] < MAXC) exp_cnt[s] = exp_cnt[s] + 1;
    end else begin
      exp_bad = 1'b1;
    end
  endtask

  // Runs one full count_begin .. count_over cycle with the queued stream.
  task automatic run_stream(input string tag, input bit noisy);
    logic [NSYM*CW-1:0] prev;
    int p0;
    prev = pack_exp();
    count_begin = 1'b1;
    step();
    count_begin = 1'b0;
    check_val({tag, "_busy_clr"}, busy, 1'b1);
    check_val({tag, "_hold_prev"}, FREQUENT_OUT, prev);
    step();
    clear_model();
    check_val({tag, "_cleared"}, FREQUENT_OUT, pack_exp());
    check_val({tag, "_bad_clr"}, bad_sym, 1'b0);
    p0 = pulses;
    for (int k = 0; k < sym_q.size(); k++) begin
      data_valid  = vld_q[k];
      DATA_IN     = SW'(sym_q[k]);
      data_last   = lst_q[k];
      count_begin = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
      if (vld_q[k]) model_symbol(sym_q[k]);
      if (k != sym_q.size() - 1 && noisy) check_val({tag, "_no_early_over"}, count_over, 1'b0);
    end
    data_valid  = $urandom_range(0, 1);
    DATA_IN     = SW'($urandom_range(0, 15));
    data_last   = $urandom_range(0, 1);
    count_begin = $urandom_range(0, 1);
    check_val({tag, "_counts"}, FREQUENT_OUT, pack_exp());
    check_val({tag, "_bad_sym"}, bad_sym, exp_bad);
    check_val({tag, "_over_at_L"}, count_over, 1'b0);
    check_val({tag, "_busy_done"}, busy, 1'b0);
    step();
    count_begin = 1'b0;
    data_valid  = 1'b1;
    check_val({tag, "_over_pulse"}, count_over, 1'b1);
    check_val({tag, "_counts_over"}, FREQUENT_OUT, pack_exp());
    for (int j = 0; j < 3; j++) begin
      DATA_IN = SW'($urandom_range(0, 9));
      step();
      check_val({tag, "_idle_stable"}, FREQUENT_OUT, pack_exp());
    end
    check_val({tag, "_over_gone"}, count_over, 1'b0);
    check_val({tag, "_one_pulse"}, 32'(pulses - p0), 32'd1);
    data_valid = 1'b0;
    data_last  = 1'b0;
    sym_q.delete();
    vld_q.delete();
    lst_q.delete();
  endtask

  initial begin
    int n;
    int s;
    bit v;
    nRST = 1'b0;
    count_begin = 1'b0;
    data_valid = 1'b0;
    DATA_IN = '0;
    data_last = 1'b0;
    clear_model();
    step();
    step();
    check_val("rst_counts", FREQUENT_OUT, '0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_over", count_over, 1'b0);
    check_val("rst_bad", bad_sym, 1'b0);
    nRST = 1'b1;
    step();

    // Basic stream.
    add(0, 1, 0); add(1, 1, 0); add(1, 1, 0); add(9, 1, 0); add(9, 1, 0); add(9, 1, 1);
    run_stream("basic", 1'b0);

    // Saturation.
    for (int k = 0; k < 8199; k++) add(5, 1, 0);
    add(5, 1, 1);
    run_stream("sat", 1'b0);
    check_val("sat_value", FREQUENT_OUT[5*CW +: CW], 13'd8191);

    // Invalid symbol ending the run, then a clean run.
    add(3, 1, 0); add(3, 1, 0); add(12, 1, 1);
    run_stream("badlast", 1'b0);
    add(4, 1, 1);
    run_stream("after_bad", 1'b0);

    // Gaps, stray data_last and count_begin noise.
    add(2, 0, 1); add(6, 1, 0); add(7, 0, 0); add(6, 1, 0); add(8, 0, 1); add(2, 1, 1);
    run_stream("gaps", 1'b1);

    // Reset mid-count.
    count_begin = 1'b1;
    step();
    count_begin = 1'b0;
    step();
    foreach (sym_q[k]) ;
    data_valid = 1'b1;
    DATA_IN = 4'd2;  step();
    DATA_IN = 4'd13; step();
    DATA_IN = 4'd2;  step();
    DATA_IN = 4'd2;  step();
    check_val("pre_rst_bad", bad_sym, 1'b1);
    n = pulses;
    #2 nRST = 1'b0;
    #1;
    check_val("mid_rst_counts", FREQUENT_OUT, '0);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_bad", bad_sym, 1'b0);
    check_val("mid_rst_over", count_over, 1'b0);
    data_valid = 1'b0;
    step();
    step();
    nRST = 1'b1;
    step();
    step();
    check_val("rst_no_pulse", 32'(pulses - n), 32'd0);
    clear_model();
    add(7, 1, 0); add(7, 1, 0); add(0, 1, 1);
    run_stream("post_rst", 1'b0);

    // Random runs.
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 40);
      for (int k = 0; k < n - 1; k++) begin
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        add(s, v, v ? 1'b0 : 1'($urandom_range(0, 1)));
      end
      s = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      add(s, 1, 1);
      run_stream("rand", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
